// File: rtl/set_assoc_cache_if.sv
// CPU request/response and memory word handshake bundle for set_assoc_cache.
// The cache sits on the slave side; the CPU/memory environment drives the master side.
interface set_assoc_cache_if;
  logic        enable;
  logic        write_enable;
  logic        byte_mode;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  enable, write_enable, byte_mode, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, ready, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output enable, write_enable, byte_mode, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, ready, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate data cache with multi-word lines,
// age-based LRU replacement and a one-word-per-ack memory handshake.
module set_assoc_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  set_assoc_cache_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W = WAY_W;
  localparam int CNT_W = (OFF_W > 0) ? OFF_W : 1;
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(WAYS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE} state_t;

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic bm,
                                               input logic [1:0] lane);
    logic [7:0] b;
    if (!bm) return w;
    b = 8'(w >> {~lane, 3'b000});
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic bm, input logic [1:0] lane);
    logic [31:0] mask;
    if (!bm) return wd;
    mask = 32'h0000_00FF << {~lane, 3'b000};
    return (old & ~mask) | ({24'b0, wd[7:0]} << {~lane, 3'b000});
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] s,
                                            input logic [CNT_W-1:0] w);
    return (32'(t) << (OFF_W + IDX_W + 2)) | (32'(s) << (OFF_W + 2)) | (32'(w) << 2);
  endfunction

  // Line storage and tags carry no reset; only valid/dirty/age qualify them.
  logic [31:0]      data_q  [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [AGE_W-1:0] age_q   [SETS][WAYS];

  state_t           state_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [WAY_W-1:0] vict_q;
  logic             replay_q;
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [31:0]      hit_cnt_q;
  logic [31:0]      miss_cnt_q;

  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic             bm_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [CNT_W-1:0] req_off;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vict;
  logic [AGE_W-1:0] best_age;
  logic [AGE_W-1:0] age_d [WAYS];
  logic [31:0]      line_word;
  logic [CNT_W-1:0] cnt_nxt;
  logic             arr_we;
  logic [WAY_W-1:0] arr_way;
  logic [CNT_W-1:0] arr_off;
  logic [31:0]      arr_wval;
  logic             tag_we;

  always_comb begin
    req_tag   = TAG_W'(addr_q >> (OFF_W + IDX_W + 2));
    req_idx   = IDX_W'(addr_q >> (OFF_W + 2));
    req_off   = CNT_W'((addr_q >> 2) & 32'(LINE_WORDS - 1));
    cnt_nxt   = word_cnt_q + 1'b1;

    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end

    // Oldest way wins (lowest index on ties) unless some way is still invalid.
    vict     = '0;
    best_age = age_q[req_idx][0];
    for (int w = 1; w < WAYS; w++) begin
      if (age_q[req_idx][w] > best_age) begin
        best_age = age_q[req_idx][w];
        vict     = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vict = WAY_W'(w);
    end

    // The <= comparison lets all-zero ages after reset settle into a permutation.
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[req_idx][w];
      if (WAY_W'(w) == hit_way)
        age_d[w] = '0;
      else if ((age_q[req_idx][w] <= age_q[req_idx][hit_way]) && (age_q[req_idx][w] != AGE_MAX))
        age_d[w] = age_q[req_idx][w] + 1'b1;
    end

    line_word = data_q[req_idx][hit_way][req_off];
    arr_we    = 1'b0;
    arr_way   = hit_way;
    arr_off   = req_off;
    arr_wval  = store_merge(line_word, wdata_q, bm_q, addr_q[1:0]);
    tag_we    = 1'b0;
    if (state_q == S_LOOKUP && hit && we_q) begin
      arr_we = 1'b1;
    end else if (state_q == S_FILL && mem_req_q && bus.mem_ack) begin
      arr_we   = 1'b1;
      arr_way  = vict_q;
      arr_off  = word_cnt_q;
      arr_wval = bus.mem_rdata;
      tag_we   = (word_cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.enable) begin
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.cpu_wdata;
      we_q    <= bus.write_enable;
      bm_q    <= bus.byte_mode;
    end
    if (arr_we) data_q[req_idx][arr_way][arr_off] <= arr_wval;
    if (tag_we) tag_q[req_idx][vict_q] <= req_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      word_cnt_q  <= '0;
      vict_q      <= '0;
      replay_q    <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: if (bus.enable) state_q <= S_LOOKUP;
        S_LOOKUP: begin
          if (hit) begin
            if (!replay_q) hit_cnt_q <= sat_inc(hit_cnt_q);
            for (int w = 0; w < WAYS; w++) age_q[req_idx][w] <= age_d[w];
            if (we_q) dirty_q[req_idx][hit_way] <= 1'b1;
            else      rdata_q <= load_extract(line_word, bm_q, addr_q[1:0]);
            ready_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            if (!replay_q) miss_cnt_q <= sat_inc(miss_cnt_q);
            vict_q     <= vict;
            word_cnt_q <= '0;
            mem_req_q  <= 1'b1;
            if (valid_q[req_idx][vict] && dirty_q[req_idx][vict]) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= line_addr(tag_q[req_idx][vict], req_idx, '0);
              mem_wdata_q <= data_q[req_idx][vict][0];
              state_q     <= S_WB;
            end else begin
              valid_q[req_idx][vict] <= 1'b0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_addr(req_tag, req_idx, '0);
              state_q    <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (bus.mem_ack) begin
            if (word_cnt_q == CNT_LAST) begin
              dirty_q[req_idx][vict_q] <= 1'b0;
              valid_q[req_idx][vict_q] <= 1'b0;
              word_cnt_q <= '0;
              mem_we_q   <= 1'b0;
              mem_addr_q <= line_addr(req_tag, req_idx, '0);
              state_q    <= S_FILL;
            end else begin
              word_cnt_q  <= cnt_nxt;
              mem_addr_q  <= line_addr(tag_q[req_idx][vict_q], req_idx, cnt_nxt);
              mem_wdata_q <= data_q[req_idx][vict_q][cnt_nxt];
            end
          end
        end
        S_FILL: begin
          if (bus.mem_ack) begin
            if (word_cnt_q == CNT_LAST) begin
              valid_q[req_idx][vict_q] <= 1'b1;
              dirty_q[req_idx][vict_q] <= 1'b0;
              mem_req_q <= 1'b0;
              replay_q  <= 1'b1;
              state_q   <= S_LOOKUP;
            end else begin
              word_cnt_q <= cnt_nxt;
              mem_addr_q <= line_addr(req_tag, req_idx, cnt_nxt);
            end
          end
        end
        S_DONE: begin
          ready_q  <= 1'b0;
          replay_q <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata  = rdata_q;
  assign bus.ready      = ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: CPU accesses against a flat golden memory,
// with a word-level memory responder that logs every accepted handshake.
module tb_set_assoc_cache;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  set_assoc_cache_if bus();
  set_assoc_cache dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int requests = 0;
  int max_delay = 0;
  int wcnt = 0;
  bit mem_init = 1'b0;
  logic [31:0] mem  [16384];
  logic [31:0] gold [16384];
  logic [32:0] log_q [$];
  logic        p_req, p_ack, p_we, p_rst;
  logic [31:0] p_addr, p_wdata;

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'hDEAD_BEEF;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic bm);
    logic [31:0] w;
    logic [7:0]  b;
    w = gold[a[15:2]];
    if (!bm) return w;
    case (a[1:0])
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return {{24{b[7]}}, b};
  endfunction

  // Memory responder: handshake on posedge, ack/rdata presented on negedge.
  always @(clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] = init_word(i);
      mem_init = 1'b1;
    end
    if (clk) begin
      if (reset === 1'b1 && p_rst && p_req && !p_ack && bus.mem_req) begin
        checks++;
        assert ({bus.mem_addr, bus.mem_wdata, bus.mem_we} === {p_addr, p_wdata, p_we})
        else begin
          failures++;
          $error("FAIL mem_stable observed=%h/%h/%b expected=%h/%h/%b",
                 bus.mem_addr, bus.mem_wdata, bus.mem_we, p_addr, p_wdata, p_we);
        end
      end
      if (bus.mem_req && bus.mem_ack) begin
        log_q.push_back({bus.mem_we, bus.mem_addr});
        if (bus.mem_we) mem[bus.mem_addr[15:2]] = bus.mem_wdata;
        wcnt = (max_delay == 0) ? 0 : $urandom_range(max_delay, 0);
      end
      p_rst = reset; p_req = bus.mem_req; p_ack = bus.mem_ack;
      p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_we = bus.mem_we;
    end else begin
      if (bus.mem_req) begin
        if (wcnt == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[15:2]];
        end else begin
          wcnt--;
          bus.mem_ack = 1'b0;
        end
      end else begin
        bus.mem_ack = (max_delay == 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic we, input logic bm, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc);
    bit got;
    @(negedge clk);
    bus.enable = 1'b1; bus.write_enable = we; bus.byte_mode = bm;
    bus.cpu_addr = a; bus.cpu_wdata = wd;
    cyc = 0; got = 1'b0;
    while (cyc < 400 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ready === 1'b1) got = 1'b1;
    end
    rd = bus.cpu_rdata;
    chk("ready_seen", 64'(got), 64'd1);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk("ready_single_pulse", 64'(bus.ready), 64'd0);
    requests++;
    if (we) begin
      if (!bm) gold[a[15:2]] = wd;
      else case (a[1:0])
        2'd0:    gold[a[15:2]][31:24] = wd[7:0];
        2'd1:    gold[a[15:2]][23:16] = wd[7:0];
        2'd2:    gold[a[15:2]][15:8]  = wd[7:0];
        default: gold[a[15:2]][7:0]   = wd[7:0];
      endcase
    end
  endtask

  logic [31:0] rd, a, exp;
  logic        we, bm;
  int          cyc, base, n;

  initial begin
    for (int i = 0; i < 16384; i++) gold[i] = init_word(i);
    reset = 1'b0;
    bus.enable = 1'b0; bus.write_enable = 1'b0; bus.byte_mode = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",     64'(bus.ready),      64'd0);
    chk("rst_mem_req",   64'(bus.mem_req),    64'd0);
    chk("rst_mem_we",    64'(bus.mem_we),     64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),   64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata),  64'd0);
    chk("rst_cpu_rdata", 64'(bus.cpu_rdata),  64'd0);
    chk("rst_hits",      64'(bus.hit_count),  64'd0);
    chk("rst_misses",    64'(bus.miss_count), 64'd0);
    @(negedge clk) reset = 1'b1;

    // Cold load, zero-wait memory
    base = log_q.size();
    access(1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    chk("t1_rdata", 64'(rd), 64'hDEAD_BEEF);
    chk("t1_latency", 64'(cyc), 64'd7);
    chk("t1_misses", 64'(bus.miss_count), 64'd1);
    chk("t1_hits", 64'(bus.hit_count), 64'd0);
    chk("t1_log_len", 64'(log_q.size()), 64'(base + 4));
    for (int w = 0; w < 4; w++) chk("t1_fill_addr", 64'(log_q[base + w]), 64'(32'h100 + 4 * w));

    // Byte load, byte store, word reload
    access(1'b0, 1'b1, 32'h103, 32'h0, rd, cyc);
    chk("t2_byte_load", 64'(rd), 64'hFFFF_FFEF);
    chk("t2_hit_latency", 64'(cyc), 64'd2);
    access(1'b1, 1'b1, 32'h101, 32'h0000_00AA, rd, cyc);
    chk("t2_store_latency", 64'(cyc), 64'd2);
    access(1'b0, 1'b0, 32'h100, 32'h0, rd, cyc);
    chk("t2_word_after_byte_store", 64'(rd), 64'hDEAA_BEEF);
    chk("t2_hits", 64'(bus.hit_count), 64'd3);
    chk("t2_misses", 64'(bus.miss_count), 64'd1);

    // Same-set conflict: dirty LRU way 0 evicted by the third tag
    access(1'b0, 1'b0, 32'h2100, 32'h0, rd, cyc);
    chk("t3_load_2100", 64'(rd), 64'(init_word(32'h840)));
    base = log_q.size();
    access(1'b0, 1'b0, 32'h4100, 32'h0, rd, cyc);
    chk("t3_load_4100", 64'(rd), 64'(init_word(32'h1040)));
    chk("t3_log_len", 64'(log_q.size()), 64'(base + 8));
    for (int w = 0; w < 4; w++) chk("t3_wb_addr", 64'(log_q[base + w]), {31'd0, 1'b1, 32'h100 + 32'(4 * w)});
    for (int w = 0; w < 4; w++) chk("t3_fill_addr", 64'(log_q[base + 4 + w]), 64'(32'h4100 + 4 * w));
    chk("t3_mem_100", 64'(mem[32'h40]), 64'hDEAA_BEEF);
    chk("t3_misses", 64'(bus.miss_count), 64'd3);
    chk("t3_hits", 64'(bus.hit_count), 64'd3);

    // Random-latency memory, mixed traffic on four sets with four tags each
    max_delay = 5;
    for (int k = 0; k < 80; k++) begin
      we = 1'($urandom_range(1, 0));
      bm = 1'($urandom_range(1, 0));
      a  = 32'(($urandom_range(3, 0) << 12) | ($urandom_range(3, 0) << 4) | ($urandom_range(3, 0) << 2));
      if (bm) a[1:0] = 2'($urandom_range(3, 0));
      exp = exp_load(a, bm);
      access(we, bm, a, $urandom, rd, cyc);
      if (!we) chk("t4_load", 64'(rd), 64'(exp));
    end
    chk("t4_hit_plus_miss", 64'(bus.hit_count + bus.miss_count), 64'(requests));

    // Reset in the middle of a line fill
    max_delay = 0;
    base = log_q.size();
    @(negedge clk);
    bus.enable = 1'b1; bus.write_enable = 1'b0; bus.byte_mode = 1'b0;
    bus.cpu_addr = 32'h8200;
    n = 0;
    while (log_q.size() < base + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_two_acks", 64'(log_q.size()), 64'(base + 2));
    reset = 1'b0;
    bus.enable = 1'b0;
    #1;
    chk("t5_req_dropped", 64'(bus.mem_req), 64'd0);
    chk("t5_ready_low", 64'(bus.ready), 64'd0);
    chk("t5_misses_cleared", 64'(bus.miss_count), 64'd0);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 16384; i++) gold[i] = mem[i];
    base = log_q.size();
    access(1'b0, 1'b0, 32'h8200, 32'h0, rd, cyc);
    chk("t5_reload", 64'(rd), 64'(init_word(32'h2080)));
    chk("t5_reload_latency", 64'(cyc), 64'd7);
    chk("t5_misses", 64'(bus.miss_count), 64'd1);
    chk("t5_hits", 64'(bus.hit_count), 64'd0);
    chk("t5_log_len", 64'(log_q.size()), 64'(base + 4));
    for (int w = 0; w < 4; w++) chk("t5_fill_addr", 64'(log_q[base + w]), 64'(32'h8200 + 4 * w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
